// File: rtl/lsu.sv
// lsu - RV32I load/store unit driving the data port of the `ram` block.
//
// Accepts one load/store per handshake, forms the effective address
// (base + sign-extended 12-bit offset), checks funct3 legality, range and
// alignment, then performs a single RAM access and returns a one-cycle
// response. Illegal requests complete with rsp_fault and never touch RAM.
//
// Parameters:
//   ADDR_W  RAM byte-address width (matches ram.d_addr)
//   RD_LAT  cycles from address presented to d_out valid (1..3)
//
// Ports:
//   clk, reset (sync, active-low)
//   req_*   request from execute: valid/ready handshake, store flag,
//           funct3, base, offset, store data
//   rsp_*   one-cycle completion pulse, load data, fault flag
//   d_*, w_en, u_en  RAM data port (address, write data, read data, size,
//           write strobe, zero-extend select)
//
// Optional feature (macro LSU_MISALIGNED_SPLIT_EN): misaligned half/word
// accesses are split into sequential byte accesses instead of faulting.
//
// state  | meaning
// IDLE   | ready for a request; decode and check it on req_valid
// ISSUE  | single RAM access cycle (w_en pulses here for stores)
// WAIT   | load: count RD_LAT cycles, then capture d_out
// RESP   | rsp_valid pulse, success
// FAULT  | rsp_valid pulse with rsp_fault, no RAM access
// SPLIT  | byte-by-byte access of a misaligned half/word (optional)

module lsu #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [11:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_fault,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_in,
  input  logic [31:0]       d_out,
  output logic [1:0]        d_size,
  output logic              w_en,
  output logic              u_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_FAULT,
    S_SPLIT
  } state_t;

  localparam logic [1:0] RD_LAT_M1 = 2'(RD_LAT - 1);

  state_t      r_state;
  logic        r_store;
  logic [1:0]  r_cnt;

  logic [31:0] w_ea;
  logic        w_oor;
  logic        w_f3_bad;
  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic        w_fault;

  assign w_ea   = req_base + {{20{req_offset[11]}}, req_offset};
  // Any address bit above the RAM window means out of range.
  assign w_oor  = (w_ea >> ADDR_W) != 32'd0;
  assign w_f3_bad = req_store ? (req_funct3 > 3'd2)
                              : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
  assign w_half = (req_funct3[1:0] == 2'd1);
  assign w_word = (req_funct3[1:0] == 2'd2);
  assign w_mis  = (w_half & w_ea[0]) | (w_word & (w_ea[1:0] != 2'd0));

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;
  logic [31:0]   r_asm;
  logic [1:0]    r_idx;
  logic [1:0]    r_last_idx;
  logic          r_rd_wait;
  logic          r_fin;
  logic [1:0]    w_next_idx;
  logic [ADDR_W:0] w_last;
  logic          w_split_oor;
  logic [31:0]   w_split_ext;

  // A split must fit entirely inside the RAM; the carry out of the
  // last-byte address flags a wrap past the top.
  assign w_last      = {1'b0, w_ea[ADDR_W-1:0]} + (w_word ? (ADDR_W+1)'(3) : (ADDR_W+1)'(1));
  assign w_split_oor = w_last[ADDR_W];
  assign w_fault     = w_oor | w_f3_bad | (w_mis & w_split_oor);
  assign w_next_idx  = r_idx + 2'd1;

  // Bytes come back zero-extended, so the LSU applies the sign itself.
  always_comb begin
    w_split_ext = r_asm;
    case (r_funct3)
      3'b001:  w_split_ext = {{16{r_asm[15]}}, r_asm[15:0]};
      3'b101:  w_split_ext = {16'h0000, r_asm[15:0]};
      default: w_split_ext = r_asm;
    endcase
  end
`else
  assign w_fault = w_oor | w_f3_bad | w_mis;
`endif

  assign req_ready = reset && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_store   <= 1'b0;
      r_cnt     <= '0;
      d_addr    <= '0;
      d_in      <= '0;
      d_size    <= '0;
      w_en      <= 1'b0;
      u_en      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_data  <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_funct3   <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_rd_wait  <= 1'b0;
      r_fin      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            if (w_fault) begin
              r_state   <= S_FAULT;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_data  <= '0;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            else if (w_mis) begin
              r_state    <= S_SPLIT;
              r_funct3   <= req_funct3;
              r_wdata    <= req_wdata;
              r_asm      <= '0;
              r_idx      <= '0;
              r_last_idx <= w_word ? 2'd3 : 2'd1;
              r_rd_wait  <= 1'b0;
              r_fin      <= 1'b0;
              r_cnt      <= RD_LAT_M1;
              d_addr     <= w_ea[ADDR_W-1:0];
              d_size     <= 2'd0;
              u_en       <= 1'b1;
              d_in       <= {24'h0, req_wdata[7:0]};
              w_en       <= req_store;
            end
`endif
            else begin
              r_state <= S_ISSUE;
              d_addr  <= w_ea[ADDR_W-1:0];
              d_size  <= req_funct3[1:0];
              u_en    <= req_funct3[2];
              d_in    <= req_wdata;
              w_en    <= req_store;
            end
          end
        end

        S_ISSUE: begin
          w_en <= 1'b0;
          if (r_store) begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_data  <= '0;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= RD_LAT_M1;
          end
        end

        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state   <= S_RESP;
            rsp_data  <= d_out;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
        end

        S_FAULT: begin
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          r_state   <= S_IDLE;
        end

`ifdef LSU_MISALIGNED_SPLIT_EN
        S_SPLIT: begin
          if (r_fin) begin
            // Extra cycle after the last byte lands, used for extension.
            r_state   <= S_RESP;
            rsp_data  <= w_split_ext;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
          end else if (r_store) begin
            if (r_idx == r_last_idx) begin
              r_state   <= S_RESP;
              w_en      <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b0;
              rsp_data  <= '0;
            end else begin
              r_idx  <= w_next_idx;
              d_addr <= d_addr + ADDR_W'(1);
              d_in   <= {24'h0, r_wdata[{w_next_idx, 3'b000} +: 8]};
              w_en   <= 1'b1;
            end
          end else if (!r_rd_wait) begin
            // Address of the current byte is on the bus this cycle.
            r_rd_wait <= 1'b1;
            r_cnt     <= RD_LAT_M1;
          end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
          end else begin
            r_asm[{r_idx, 3'b000} +: 8] <= d_out[7:0];
            r_rd_wait <= 1'b0;
            if (r_idx == r_last_idx) begin
              r_fin <= 1'b1;
            end else begin
              r_idx  <= w_next_idx;
              d_addr <= d_addr + ADDR_W'(1);
            end
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
